analyze_result_buffer: RTL and testbench
========================================

// Module: analyze_result_buffer
// PURPOSE
//  Downstream of analyze_fsm: captures each 80-bit result word (output_channels + data_output_trigger)
//  into a FIFO and drains it to the data3 FCx5 output stream (drain_mode=1) or to the host over the
//  HVI memory port (drain_mode=0). Replaces the direct analyze_fsm->data3 wiring in demod_main;
//  adds overflow accounting so no result is lost silently.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of 2, >=2
//  DATA_W  80  result width (5 x 16-bit FCx5 words)
//  CNT_W   16  drop-counter width (saturating)
// PORTS
//  clk               in   1       system clock (100 MHz domain)
//  rst_n             in   1       async active-low reset
//  drain_mode        in   1       1=stream drain, 0=host drain; sampled every cycle
//  res_valid         in   1       1-cycle pulse from analyze_fsm data_output_trigger
//  res_data          in   80      analyze_fsm output_channels; [15:0]=word0 ... [79:64]=word4
//  hvi_address       in   10      HVI_sdi_mem_S_address
//  hvi_rdEn          in   1       HVI read strobe
//  hvi_wrEn          in   1       HVI write strobe
//  hvi_wrData        in   32      HVI write data (content ignored)
//  hvi_rdData        out  32      registered read data
//  out_data_0..4     out  16 ea   data3 stream words 0..4
//  out_valid         out  1       data3 stream valid
//  count             out  log2(DEPTH)+1  entries held
//  overflow          out  1       sticky: a result was dropped
// BEHAVIOUR
//  Reset: pointers, count, overflow, drop_cnt, out_data_*, out_valid, hvi_rdData all 0, async assert.
//  Push: res_valid & (~full | pop_this_cycle) -> write res_data at tail. Full with no pop -> drop,
//   overflow<=1, drop_cnt+=1 saturating at 2^CNT_W-1.
//  Stream drain (drain_mode=1): each cycle with ~empty pops head into output regs, out_valid<=1;
//   else out_valid<=0, out_data_* hold. Throughput 1 entry/cycle; res_valid at edge N into empty
//   FIFO -> out_valid high for the cycle after edge N+1 (1-cycle FIFO latency).
//  Host drain (drain_mode=0): out_valid<=0. HVI map (word addresses):
//   0x000 R  status {overflow[31], empty[30], 6'b0, drop_cnt[23:8], count zero-ext [7:0]}
//   0x001 R  {word1, word0} of head; 0x002 R {word3, word2}; 0x003 R {16'b0, word4}
//   0x004 W  pop head (ignored if empty or drain_mode=1)
//   0x005 W  clear overflow and drop_cnt
//   Reads: hvi_rdData valid the cycle after hvi_rdEn; head reads when empty return 0;
//   unmapped addresses read 0, writes ignored. hvi_rdData holds between reads.
//  Simultaneous: push+pop when full -> both happen, count unchanged; push+pop when empty -> push only.
//   Clear (0x005) and a drop in the same cycle -> drop wins (overflow=1, drop_cnt=1).
//   Read of 0x001-0x003 and pop in the same cycle -> read returns pre-pop head.
//  drain_mode change: takes effect next cycle; no entry lost or duplicated; an in-flight
//   out_valid completes.
//  Wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty from count.
// STRUCTURE
//  demod_pkg: HVI address constants (ADDR_STATUS, ADDR_HEAD01, ADDR_HEAD23, ADDR_HEAD4,
//   ADDR_POP, ADDR_CLR), status bit positions, FCX5_WORDS=5.
//  Sub-module result_fifo: generic sync FIFO (push, pop, head, count, full, empty); this block
//   adds drop logic, drain muxing and HVI decode.
// TESTING
//  1 Stream: drain_mode=1, 3 pulses res_data=80'h0004_0003_0002_0001_0000+k -> 3 out_valid beats,
//    in order, out_data_0=0000+k, out_data_4=0004, first beat 2 edges after first pulse.
//  2 Overflow: drain_mode=0, 18 pulses -> count=16, status=0x8000_0210; 0x005 write -> 0x0000_0010.
//  3 Host drain: push A,B; read 0x001/2/3 -> A words; write 0x004; reads -> B; pop -> status empty bit=1.
//  4 Full+push+pop same cycle (stream mode, FIFO pre-filled 16) -> count stays 16, no drop.
//  5 Reset mid-stream: rst_n low while out_valid=1 -> all outputs 0 immediately, count=0.
//  6 Mode switch with 5 entries mid-drain -> total beats + host pops = 5, no duplicates.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared constants for the analyze result buffer:
// HVI register map, status layout and FCx5 framing.
package demod_pkg;

   localparam int FCX5_WORDS = 5;
   localparam int WORD_W     = 16;

   localparam logic [9:0] ADDR_STATUS = 10'h000;
   localparam logic [9:0] ADDR_HEAD01 = 10'h001;
   localparam logic [9:0] ADDR_HEAD23 = 10'h002;
   localparam logic [9:0] ADDR_HEAD4  = 10'h003;
   localparam logic [9:0] ADDR_POP    = 10'h004;
   localparam logic [9:0] ADDR_CLR    = 10'h005;

   localparam int ST_OVF_BIT   = 31;
   localparam int ST_EMPTY_BIT = 30;
   localparam int ST_DROP_LSB  = 8;
   localparam int ST_CNT_LSB   = 0;

   // Assemble the status word from its fields
   function automatic logic [31:0] status_word(
      input logic        ovf,
      input logic        empty,
      input logic [15:0] drop,
      input logic [7:0]  cnt
   );
      logic [31:0] s;
      s                           = '0;
      s[ST_OVF_BIT]               = ovf;
      s[ST_EMPTY_BIT]             = empty;
      s[ST_DROP_LSB +: 16]        = drop;
      s[ST_CNT_LSB +: 8]          = cnt;
      return s;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO: head is visible combinationally,
// full/empty are derived from the entry count.
module result_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 80
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_q];
   assign count   = cnt_q;

   // Pointer and occupancy next-state
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= wdata;
   end

endmodule

// File: rtl/analyze_result_buffer.sv
// Buffers analyze_fsm results and drains them either to the
// data3 stream or to the host via HVI, counting dropped results.
module analyze_result_buffer
   import demod_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 80,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   drain_mode,
   input  logic                   res_valid,
   input  logic [DATA_W-1:0]      res_data,
   input  logic [9:0]             hvi_address,
   input  logic                   hvi_rdEn,
   input  logic                   hvi_wrEn,
   input  logic [31:0]            hvi_wrData,
   output logic [31:0]            hvi_rdData,
   output logic [15:0]            out_data_0,
   output logic [15:0]            out_data_1,
   output logic [15:0]            out_data_2,
   output logic [15:0]            out_data_3,
   output logic [15:0]            out_data_4,
   output logic                   out_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] head_v;
   logic [CW-1:0]     cnt;
   logic              full, empty;
   logic              push, pop, drop, clr, host_pop;

   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  drop_base;
   logic [DATA_W-1:0] out_q, out_d;
   logic              vld_q, vld_d;
   logic [31:0]       rd_q, rd_d;
   logic              unused_wr;

   result_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (res_data),
      .head  (head),
      .count (cnt),
      .full  (full),
      .empty (empty)
   );

   assign unused_wr = ^hvi_wrData;
   assign host_pop  = ~drain_mode & hvi_wrEn
                    & (hvi_address == ADDR_POP);
   assign pop       = ~empty & (drain_mode | host_pop);
   assign push      = res_valid & (~full | pop);
   assign drop      = res_valid & full & ~pop;
   assign clr       = hvi_wrEn & (hvi_address == ADDR_CLR);
   assign head_v    = empty ? '0 : head;

   // Overflow accounting, stream output and HVI read mux
   always_comb begin
      ovf_d     = ovf_q;
      drop_base = clr ? '0 : drop_q;
      drop_d    = drop_base;
      out_d     = out_q;
      vld_d     = 1'b0;
      rd_d      = rd_q;
      if (clr) ovf_d = 1'b0;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_base != '1) drop_d = drop_base + CNT_W'(1);
      end
      if (drain_mode && pop) begin
         out_d = head;
         vld_d = 1'b1;
      end
      if (hvi_rdEn) begin
         unique case (1'b1)
            (hvi_address == ADDR_STATUS):
               rd_d = status_word(ovf_q, empty,
                                  16'(drop_q), 8'(cnt));
            (hvi_address == ADDR_HEAD01):
               rd_d = head_v[31:0];
            (hvi_address == ADDR_HEAD23):
               rd_d = head_v[63:32];
            (hvi_address == ADDR_HEAD4):
               rd_d = {16'b0, head_v[79:64]};
            default:
               rd_d = '0;
         endcase
      end
   end

   // Output and accounting registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
         rd_q   <= '0;
      end else begin
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
         out_q  <= out_d;
         vld_q  <= vld_d;
         rd_q   <= rd_d;
      end
   end

   assign out_data_0 = out_q[0*WORD_W +: WORD_W];
   assign out_data_1 = out_q[1*WORD_W +: WORD_W];
   assign out_data_2 = out_q[2*WORD_W +: WORD_W];
   assign out_data_3 = out_q[3*WORD_W +: WORD_W];
   assign out_data_4 = out_q[(FCX5_WORDS-1)*WORD_W +: WORD_W];
   assign out_valid  = vld_q;
   assign count      = cnt;
   assign overflow   = ovf_q;
   assign hvi_rdData = rd_q;

endmodule

// File: tb/tb_analyze_result_buffer.sv
// Randomised bench for analyze_result_buffer with a queue-based
// reference model plus directed scenarios.
module tb_analyze_result_buffer;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst_n;
   logic        drain_mode;
   logic        res_valid;
   logic [79:0] res_data;
   logic [9:0]  hvi_address;
   logic        hvi_rdEn;
   logic        hvi_wrEn;
   logic [31:0] hvi_wrData;
   logic [31:0] hvi_rdData;
   logic [15:0] out_data_0, out_data_1, out_data_2;
   logic [15:0] out_data_3, out_data_4;
   logic        out_valid;
   logic [4:0]  count;
   logic        overflow;

   analyze_result_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .drain_mode  (drain_mode),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .hvi_address (hvi_address),
      .hvi_rdEn    (hvi_rdEn),
      .hvi_wrEn    (hvi_wrEn),
      .hvi_wrData  (hvi_wrData),
      .hvi_rdData  (hvi_rdData),
      .out_data_0  (out_data_0),
      .out_data_1  (out_data_1),
      .out_data_2  (out_data_2),
      .out_data_3  (out_data_3),
      .out_data_4  (out_data_4),
      .out_valid   (out_valid),
      .count       (count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag,
                        input logic [79:0] got,
                        input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: a queue of results plus visible registers
   logic [79:0] q[$];
   logic        m_ovf;
   int          m_drop;
   logic [79:0] m_out;
   logic        m_valid;
   logic [31:0] m_rd;

   task automatic model_reset();
      q.delete();
      m_ovf   = 1'b0;
      m_drop  = 0;
      m_out   = '0;
      m_valid = 1'b0;
      m_rd    = '0;
   endtask

   task automatic model_step();
      int          n;
      bit          emp, ful, pp;
      logic [79:0] h;
      logic [15:0] d16;
      n   = q.size();
      emp = (n == 0);
      ful = (n == DEPTH);
      h   = emp ? 80'h0 : q[0];
      pp  = !emp && (drain_mode ||
             (hvi_wrEn && hvi_address == 10'h004));
      if (hvi_rdEn) begin
         d16 = m_drop[15:0];
         case (hvi_address)
            10'h000: m_rd = {m_ovf, emp, 6'b0, d16, 8'(n)};
            10'h001: m_rd = h[31:0];
            10'h002: m_rd = h[63:32];
            10'h003: m_rd = {16'h0, h[79:64]};
            default: m_rd = 32'h0;
         endcase
      end
      if (drain_mode && pp) begin
         m_out   = h;
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (hvi_wrEn && hvi_address == 10'h005) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      if (res_valid && ful && !pp) begin
         m_ovf = 1'b1;
         if (m_drop < 65535) m_drop++;
      end
      if (pp) void'(q.pop_front());
      if (res_valid && (!ful || pp)) q.push_back(res_data);
   endtask

   task automatic compare_all();
      check("count", count, q.size());
      check("overflow", overflow, m_ovf);
      check("out_valid", out_valid, m_valid);
      check("out_data", {out_data_4, out_data_3, out_data_2,
                         out_data_1, out_data_0}, m_out);
      check("hvi_rdData", hvi_rdData, m_rd);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      res_valid   = 1'b0;
      hvi_rdEn    = 1'b0;
      hvi_wrEn    = 1'b0;
      hvi_address = '0;
   endtask

   task automatic hvi_read(input logic [9:0] a);
      idle();
      hvi_rdEn    = 1'b1;
      hvi_address = a;
      cycle();
      idle();
   endtask

   task automatic hvi_write(input logic [9:0] a);
      idle();
      hvi_wrEn    = 1'b1;
      hvi_address = a;
      hvi_wrData  = $urandom();
      cycle();
      idle();
   endtask

   function automatic logic [79:0] rnd80();
      return 80'({$urandom(), $urandom(), $urandom()});
   endfunction

   logic [79:0] a_val, b_val, base;
   int          beats, pops;

   initial begin
      rst_n      = 1'b0;
      drain_mode = 1'b0;
      res_data   = '0;
      hvi_wrData = '0;
      idle();
      model_reset();
      #12;
      compare_all();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Stream: three pulses, first beat two edges after first pulse
      drain_mode = 1'b1;
      base       = 80'h0004_0003_0002_0001_0000;
      for (int k = 0; k < 3; k++) begin
         res_valid = 1'b1;
         res_data  = base + 80'(k);
         cycle();
         if (k == 0) check("t1_no_beat_yet", out_valid, 1'b0);
         if (k == 1) begin
            check("t1_first_valid", out_valid, 1'b1);
            check("t1_first_w0", out_data_0, 16'h0000);
            check("t1_first_w4", out_data_4, 16'h0004);
         end
      end
      idle();
      cycle();
      check("t1_last_w0", out_data_0, 16'h0002);
      for (int k = 0; k < 3; k++) cycle();

      // Overflow: 18 pulses into host-mode FIFO
      drain_mode = 1'b0;
      for (int k = 0; k < 18; k++) begin
         res_valid = 1'b1;
         res_data  = rnd80();
         cycle();
      end
      hvi_read(10'h000);
      check("t2_status", hvi_rdData, 32'h8000_0210);
      hvi_write(10'h005);
      hvi_read(10'h000);
      check("t2_status_clr", hvi_rdData, 32'h0000_0010);

      // Host drain: empty, push A and B, read and pop
      for (int k = 0; k < DEPTH; k++) hvi_write(10'h004);
      check("t3_emptied", count, 5'd0);
      a_val = rnd80();
      b_val = rnd80();
      res_valid = 1'b1;
      res_data  = a_val;
      cycle();
      res_data  = b_val;
      cycle();
      hvi_read(10'h001);
      check("t3_a01", hvi_rdData, a_val[31:0]);
      hvi_read(10'h002);
      hvi_read(10'h003);
      hvi_write(10'h004);
      hvi_read(10'h001);
      check("t3_b01", hvi_rdData, b_val[31:0]);
      hvi_read(10'h002);
      hvi_read(10'h003);
      hvi_write(10'h004);
      hvi_read(10'h000);
      check("t3_empty_bit", hvi_rdData[30], 1'b1);

      // Full FIFO, switch to stream with simultaneous push
      for (int k = 0; k < DEPTH; k++) begin
         res_valid = 1'b1;
         res_data  = rnd80();
         cycle();
      end
      drain_mode = 1'b1;
      res_valid  = 1'b1;
      res_data   = rnd80();
      cycle();
      check("t4_count", count, 5'd16);
      check("t4_no_drop", overflow, 1'b0);

      // Reset while the stream is emitting
      idle();
      cycle();
      check("t5_pre_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("t5_w0", out_data_0, 16'h0);
      #3;
      rst_n = 1'b1;
      drain_mode = 1'b0;
      cycle();

      // Mode switch mid-drain: no loss, no duplicates
      for (int k = 0; k < 5; k++) begin
         res_valid = 1'b1;
         res_data  = rnd80();
         cycle();
      end
      idle();
      beats = 0;
      pops  = 0;
      drain_mode = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle();
         if (out_valid) beats++;
      end
      drain_mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (q.size() > 0) pops++;
         hvi_wrEn    = 1'b1;
         hvi_address = 10'h004;
         cycle();
         if (out_valid) beats++;
      end
      idle();
      check("t6_total", beats + pops, 5);
      check("t6_count", count, 5'd0);

      // Random traffic
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 63) == 0) drain_mode = ~drain_mode;
         res_valid   = ($urandom_range(0, 1) == 1);
         res_data    = rnd80();
         hvi_rdEn    = ($urandom_range(0, 2) == 0);
         hvi_wrEn    = ($urandom_range(0, 3) == 0);
         hvi_address = 10'($urandom_range(0, 7));
         hvi_wrData  = $urandom();
         if ($urandom_range(0, 99) == 0)
            hvi_address = 10'($urandom_range(8, 1023));
         cycle();
      end
      idle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
